mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single memory port between instruction fetch (requester 0) and data load/store
//  (requester 1). Round-robin two-state-plus-ack FSM; drives sel of two 32-bit 2:1 muxes
//  (address, write data) and a watchdog that aborts transfers the memory never completes.
// PARAMETERS
//  TIMEOUT  16  max BUSY cycles without mem_ready before abort; 0 = watchdog disabled
//  CNT_W    5   watchdog counter width; must satisfy 2**CNT_W > TIMEOUT
// PORTS
//  clk        in   1   single clock, rising edge
//  reset      in   1   asynchronous, active-high
//  req        in   2   req[i]: requester i wants a transfer; held high until its ack
//  addr0      in   32  requester 0 address
//  addr1      in   32  requester 1 address
//  wdata0     in   32  requester 0 write data
//  wdata1     in   32  requester 1 write data
//  we         in   2   we[i]: requester i transfer is a write
//  ack        out  2   one-cycle completion pulse to owner
//  err        out  2   one-cycle abort pulse to owner (coincident with ack)
//  rdata      out  32  registered read data, valid while ack high
//  busy       out  1   high in BUSY and DONE
//  sel        out  1   current owner; mux select (0 = requester 0)
//  mem_req    out  1   transfer request to memory
//  mem_addr   out  32  sel ? addr1 : addr0 (combinational mux)
//  mem_wdata  out  32  sel ? wdata1 : wdata0 (combinational mux)
//  mem_we     out  1   we[sel] gated by mem_req
//  mem_ready  in   1   memory completes transfer this cycle
//  mem_rdata  in   32  memory read data, valid with mem_ready
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, sel=0, last=1, cnt=0, mem_req=0, ack=0, err=0,
//   rdata=0, busy=0. Aborts any in-flight transfer; memory sees mem_req fall immediately.
//  States IDLE, BUSY, DONE; all outputs except muxes/mem_we registered.
//  IDLE: no req -> stay. One req -> grant it. Both -> grant ~last (requester 0 wins first
//   after reset). Grant edge: sel<=winner, mem_req<=1, cnt<=0, state<=BUSY.
//  BUSY: sel, mem_req held. Edge with mem_ready=1: mem_req<=0, ack[sel]<=1,
//   rdata<=mem_we?0:mem_rdata, last<=sel, state<=DONE. Min latency req->ack = 2 cycles.
//  Watchdog (TIMEOUT>0): cnt++ each BUSY cycle without mem_ready; edge where
//   cnt==TIMEOUT-1 and mem_ready=0 -> same as completion but err[sel]<=1, rdata<=0.
//   mem_ready and timeout on same edge: completion wins, err stays 0.
//  DONE: exactly one cycle; ack/err cleared, state<=IDLE. sel unchanged until next grant.
//  Requester drops req on the edge ending DONE; req still high in IDLE = new request.
//  Fairness: with both req held continuously, grants strictly alternate 0,1,0,1...
//  req changes during BUSY/DONE ignored; addr/wdata/we of owner must be stable in BUSY.
//  Never more than one ack bit set; ack never asserted outside DONE.
// TESTING
//  1 Reset, req=01, addr0=0x00400000, mem_ready 3 cycles after mem_req, mem_rdata=
//    0x8C080004 -> mem_addr=0x00400000, ack=01 one cycle, rdata=0x8C080004, err=00.
//  2 req=11 held, mem_ready=1 every BUSY cycle -> grant order 0,1,0,1; each ack 3 cycles apart.
//  3 req=10, we=10, wdata1=0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF, sel=1, rdata=0.
//  4 TIMEOUT=16, mem_ready held 0 -> ack[owner]=1 and err[owner]=1 on 16th BUSY cycle edge,
//    mem_req falls; variant with mem_ready=1 on that edge -> err=00.
//  5 reset pulsed mid-BUSY -> mem_req=0, busy=0, sel=0 immediately; next req=11 grants 0.
//  6 Random req/mem_ready 10k cycles; checker: ack one-hot-or-zero, no starvation >2 grants.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin owner selection for the single memory port shared by
// instruction fetch (requester 0) and data load/store (requester 1). A three-state FSM
// (IDLE -> BUSY -> DONE) drives the address/write-data mux select and a watchdog that
// aborts transfers the memory never completes.
module mem_port_arbiter #(
  parameter int TIMEOUT = 16,  // BUSY cycles without mem_ready before abort; 0 disables
  parameter int CNT_W   = 5    // watchdog counter width, 2**CNT_W > TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [31:0]       addr0,
  input  logic [31:0]       addr1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  input  logic [1:0]        we,
  output logic [1:0]        ack,
  output logic [1:0]        err,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              sel,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter value seen on the last BUSY cycle before the watchdog fires.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_d;
  logic             last, last_d;     // owner of the most recently finished transfer
  logic [CNT_W-1:0] cnt, cnt_d;       // BUSY cycles spent waiting on mem_ready
  logic             sel_d;
  logic             mem_req_d;
  logic [1:0]       ack_d, err_d;
  logic [31:0]      rdata_d;
  logic             busy_d;
  logic             winner;
  logic             timeout_hit;

  // The memory sees the owner's address and data straight through the muxes.
  assign mem_addr    = sel ? addr1 : addr0;
  assign mem_wdata   = sel ? wdata1 : wdata0;
  assign mem_we      = mem_req & we[sel];
  assign timeout_hit = (TIMEOUT != 0) && (cnt == TMO_LAST);

  // Next-state and next-output logic: arbitration in IDLE, completion/abort in BUSY.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch can be inferred.
    state_d   = state;
    sel_d     = sel;
    last_d    = last;
    cnt_d     = cnt;
    mem_req_d = mem_req;
    ack_d     = 2'b00;
    err_d     = 2'b00;
    rdata_d   = rdata;
    winner    = 1'b0;

    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          // Contention goes to whoever did not finish last; a lone request just wins.
          if (req == 2'b11) winner = ~last;
          else              winner = req[1];
          sel_d     = winner;
          mem_req_d = 1'b1;
          cnt_d     = '0;
          state_d   = BUSY;
        end
      end

      BUSY: begin
        if (mem_ready) begin
          // Completion takes priority over a watchdog expiring on the same edge.
          mem_req_d  = 1'b0;
          ack_d[sel] = 1'b1;
          rdata_d    = mem_we ? 32'h0 : mem_rdata;
          last_d     = sel;
          state_d    = DONE;
        end else if (timeout_hit) begin
          mem_req_d  = 1'b0;
          ack_d[sel] = 1'b1;
          err_d[sel] = 1'b1;
          rdata_d    = 32'h0;
          last_d     = sel;
          state_d    = DONE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State register and registered outputs; reset aborts any transfer immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sel     <= 1'b0;
      last    <= 1'b1;
      cnt     <= '0;
      mem_req <= 1'b0;
      ack     <= 2'b00;
      err     <= 2'b00;
      rdata   <= 32'h0;
      busy    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state   <= state_d;
      sel     <= sel_d;
      last    <= last_d;
      cnt     <= cnt_d;
      mem_req <= mem_req_d;
      ack     <= ack_d;
      err     <= err_d;
      rdata   <= rdata_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by randomized
// requesters and memory, all compared cycle by cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [1:0]  we;
  logic [1:0]  ack, err;
  logic [31:0] rdata;
  logic        busy, sel, mem_req;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_we;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .we        (we),
    .ack       (ack),
    .err       (err),
    .rdata     (rdata),
    .busy      (busy),
    .sel       (sel),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cycle    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // Transaction-level model: who owns the port, whether a transfer is outstanding,
  // how long it has waited, and the one-cycle completion report.
  int          m_owner;
  bit          m_active;     // a transfer has been granted and not yet finished
  bit          m_report;     // the completion report is being shown this cycle
  int          m_waited;     // cycles the outstanding transfer has waited
  int          m_last;       // owner of the most recently finished transfer
  logic [1:0]  m_ack, m_err;
  logic [31:0] m_rdata;
  int          starve[2];    // grants handed to the other side while this one waited

  task automatic model_reset();
    m_owner  = 0;
    m_active = 0;
    m_report = 0;
    m_waited = 0;
    m_last   = 1;
    m_ack    = 2'b00;
    m_err    = 2'b00;
    m_rdata  = 32'h0;
    starve[0] = 0;
    starve[1] = 0;
  endtask

  task automatic model_finish(input bit aborted, input logic [31:0] data);
    m_ack[m_owner] = 1'b1;
    m_err[m_owner] = aborted;
    m_rdata        = data;
    m_last         = m_owner;
    m_active       = 0;
    m_report       = 1;
  endtask

  // Advance the model across one clock edge given the inputs present at that edge.
  task automatic model_edge(input logic [1:0] r, input logic [1:0] w, input logic rdy,
                            input logic [31:0] rd);
    int win;
    m_ack = 2'b00;
    m_err = 2'b00;
    if (m_report) begin
      m_report = 0;
    end else if (m_active) begin
      if (rdy)                                        model_finish(0, w[m_owner] ? 32'h0 : rd);
      else if (TIMEOUT > 0 && m_waited + 1 == TIMEOUT) model_finish(1, 32'h0);
      else                                            m_waited++;
    end else if (r != 2'b00) begin
      if (r == 2'b11) win = 1 - m_last;
      else            win = r[1] ? 1 : 0;
      if (r[1 - win]) starve[1 - win]++;
      starve[win] = 0;
      check("no_starvation", 32'(starve[1 - win] > 2), 32'h0);
      m_owner  = win;
      m_active = 1;
      m_waited = 0;
    end
  endtask

  task automatic compare_outputs();
    check("ack",       {30'h0, ack},   {30'h0, m_ack});
    check("err",       {30'h0, err},   {30'h0, m_err});
    check("rdata",     rdata,          m_rdata);
    check("busy",      32'(busy),      32'(m_active || m_report));
    check("sel",       32'(sel),       32'(m_owner));
    check("mem_req",   32'(mem_req),   32'(m_active));
    check("mem_addr",  mem_addr,       (m_owner != 0) ? addr1 : addr0);
    check("mem_wdata", mem_wdata,      (m_owner != 0) ? wdata1 : wdata0);
    check("mem_we",    32'(mem_we),    32'(m_active && we[m_owner]));
    check("ack_onehot0", 32'($onehot0(ack)), 32'h1);
    check("err_within_ack", {30'h0, err & ~ack}, 32'h0);
  endtask

  // One clock: capture inputs, let the edge happen, update model, compare 1 ns later.
  task automatic step();
    logic [1:0]  r, w;
    logic        rdy;
    logic [31:0] rd;
    r   = req;
    w   = we;
    rdy = mem_ready;
    rd  = mem_rdata;
    @(posedge clk);
    #1;
    cycle++;
    if (reset) model_reset();
    else       model_edge(r, w, rdy, rd);
    compare_outputs();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    model_reset();
    compare_outputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  int         ack_cycle;
  int         prev_ack_cycle;
  bit         pend[2];

  initial begin
    reset     = 1'b0;
    req       = 2'b00;
    we        = 2'b00;
    addr0     = 32'h0;
    addr1     = 32'h0;
    wdata0    = 32'h0;
    wdata1    = 32'h0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    #2;
    apply_reset();

    // 1: single fetch, memory answers on the third BUSY cycle.
    addr0 = 32'h0040_0000;
    addr1 = 32'h1000_0010;
    req   = 2'b01;
    step();
    check("t1_mem_addr", mem_addr, 32'h0040_0000);
    check("t1_mem_req", 32'(mem_req), 32'h1);
    mem_rdata = 32'h8C08_0004;
    step();
    step();
    mem_ready = 1'b1;
    step();
    check("t1_ack", {30'h0, ack}, 32'h1);
    check("t1_rdata", rdata, 32'h8C08_0004);
    check("t1_err", {30'h0, err}, 32'h0);
    req       = 2'b00;
    mem_ready = 1'b0;
    step();
    check("t1_ack_cleared", {30'h0, ack}, 32'h0);

    // 2: both requesting continuously, memory always ready -> strict alternation.
    apply_reset();
    req       = 2'b11;
    mem_ready = 1'b1;
    prev_ack_cycle = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("t2_grant_order", 32'(sel), 32'(k % 2));
      step();
      ack_cycle = cycle;
      check("t2_ack", {30'h0, ack}, 32'(2'b01 << (k % 2)));
      if (k > 0) check("t2_ack_spacing", 32'(ack_cycle - prev_ack_cycle), 32'd3);
      prev_ack_cycle = ack_cycle;
      step();
    end
    req       = 2'b00;
    mem_ready = 1'b0;
    step();

    // 3: data-side write; read data must report zero.
    req       = 2'b10;
    we        = 2'b10;
    wdata1    = 32'hDEAD_BEEF;
    mem_rdata = 32'h1234_5678;
    step();
    check("t3_mem_we", 32'(mem_we), 32'h1);
    check("t3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("t3_sel", 32'(sel), 32'h1);
    mem_ready = 1'b1;
    step();
    check("t3_ack", {30'h0, ack}, 32'h2);
    check("t3_rdata", rdata, 32'h0);
    req       = 2'b00;
    we        = 2'b00;
    mem_ready = 1'b0;
    step();

    // 4a: memory never answers -> abort on the edge ending the 16th BUSY cycle.
    req = 2'b01;
    step();
    for (int k = 0; k < TIMEOUT - 1; k++) begin
      step();
      check("t4_still_waiting", 32'(mem_req), 32'h1);
    end
    step();
    check("t4_abort_ack", {30'h0, ack}, 32'h1);
    check("t4_abort_err", {30'h0, err}, 32'h1);
    check("t4_mem_req_fell", 32'(mem_req), 32'h0);
    req = 2'b00;
    step();

    // 4b: memory answers on exactly the timeout edge -> completion, no error.
    req       = 2'b10;
    mem_rdata = 32'hCAFE_F00D;
    step();
    for (int k = 0; k < TIMEOUT - 1; k++) step();
    mem_ready = 1'b1;
    step();
    check("t4b_ack", {30'h0, ack}, 32'h2);
    check("t4b_err", {30'h0, err}, 32'h0);
    check("t4b_rdata", rdata, 32'hCAFE_F00D);
    req       = 2'b00;
    mem_ready = 1'b0;
    step();

    // 5: finish a fetch (owner 0 finishes last), start a data transfer, reset mid-BUSY.
    req       = 2'b01;
    mem_ready = 1'b1;
    step();
    step();
    req       = 2'b00;
    step();
    req       = 2'b10;
    mem_ready = 1'b0;
    step();
    step();
    check("t5_owner_before_reset", 32'(sel), 32'h1);
    reset = 1'b1;
    #1;
    model_reset();
    check("t5_mem_req_async", 32'(mem_req), 32'h0);
    check("t5_busy_async", 32'(busy), 32'h0);
    check("t5_sel_async", 32'(sel), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    req   = 2'b11;
    step();
    check("t5_grant_after_reset", 32'(sel), 32'h0);
    mem_ready = 1'b1;
    step();
    req       = 2'b00;
    mem_ready = 1'b0;
    step();

    // 6: random requesters (hold until ack) and a lazy memory.
    pend[0] = 0;
    pend[1] = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (ack[i]) pend[i] = 0;
        if (!pend[i] && $urandom_range(2) == 0) begin
          pend[i] = 1;
          we[i]   = 1'($urandom_range(1));
          if (i == 0) begin
            addr0  = $urandom;
            wdata0 = $urandom;
          end else begin
            addr1  = $urandom;
            wdata1 = $urandom;
          end
        end
      end
      req       = {pend[1], pend[0]};
      mem_ready = ($urandom_range(5) == 0);
      mem_rdata = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
